// File: rtl/uart_frame_reader_pkg.sv
// uart_frame_reader_pkg: shared image-transfer constants and FSM state encodings
package uart_frame_reader_pkg;
  localparam int IMG_ADDR_W = 16;
  localparam int IMG_BYTES = 65536;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_TX = 3'd4,
    S_FINISH  = 3'd5
  } state_e;
endpackage

// File: rtl/uart_frame_reader_if.sv
// uart_frame_reader_if: mode-control, DRAM read and UART transmit signals of the frame reader
interface uart_frame_reader_if
  import uart_frame_reader_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = 8
) ();
  logic start;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic tx_dv;
  logic [DATA_W-1:0] tx_byte;
  logic tx_done;
  modport master (
    input  start, ram_q, tx_done,
    output busy, done, ram_addr, tx_dv, tx_byte
  );
  modport slave (
    output start, ram_q, tx_done,
    input  busy, done, ram_addr, tx_dv, tx_byte
  );
endinterface

// File: rtl/uart_frame_reader_rd_lat_delay.sv
// uart_frame_reader_rd_lat_delay: down-counter flagging DRAM data valid RD_LAT cycles after a fetch
module uart_frame_reader_rd_lat_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic valid_o
);
  logic [1:0] cnt_q, cnt_d;
  assign valid_o = cnt_q == 2'd1;
  // reload on fetch, otherwise count down and rest at zero
  always_comb cnt_d = load_i ? 2'(RD_LAT) : (cnt_q != 2'd0 ? cnt_q - 2'd1 : cnt_q);
  // latency counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 2'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_frame_reader.sv
// uart_frame_reader: streams a contiguous DRAM block into the UART transmitter, one byte per tx_done
module uart_frame_reader
  import uart_frame_reader_pkg::*;
#(
  parameter int ADDR_W    = IMG_ADDR_W,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int NUM_BYTES = IMG_BYTES,
  parameter int RD_LAT    = 1
) (
  input logic clk,
  input logic rst,
  uart_frame_reader_if.master bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic rd_valid;
  logic fetching;
  uart_frame_reader_rd_lat_delay #(.RD_LAT(RD_LAT)) u_rd_lat (
    .clk(clk),
    .rst(rst),
    .load_i(state_q == S_FETCH),
    .valid_o(rd_valid)
  );
  assign fetching = state_q == S_FETCH || state_q == S_WAIT_RD;
  assign bus.ram_addr = fetching ? addr_q : ram_addr_q;
  assign bus.tx_dv = state_q == S_SEND;
  assign bus.tx_byte = byte_q;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_FINISH;
  // state, address, byte counter and transmit byte registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= ADDR_W'(BASE_ADDR);
      ram_addr_q <= ADDR_W'(BASE_ADDR);
      rem_q <= '0;
      byte_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      ram_addr_q <= ram_addr_d;
      rem_q <= rem_d;
      byte_q <= byte_d;
    end
  end
  // next state; ram_addr_q remembers the last fetched address so the bus holds it between fetches
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    byte_d = byte_q;
    ram_addr_d = fetching ? addr_q : ram_addr_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        addr_d = ADDR_W'(BASE_ADDR);
        rem_d = (ADDR_W+1)'(NUM_BYTES);
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT_RD;
      S_WAIT_RD: if (rd_valid) begin
        byte_d = bus.ram_q;
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: if (bus.tx_done) begin
        rem_d = rem_q - 1'b1;
        addr_d = addr_q + 1'b1;
        state_d = rem_q == (ADDR_W+1)'(1) ? S_FINISH : S_FETCH;
      end
      S_FINISH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: doc/uart_frame_reader.md
# uart_frame_reader

Reads a contiguous block of bytes out of the image DRAM and streams them, one at a time, into the UART transmitter. It waits for each transmit-done before fetching the next byte. It is the read-side counterpart of the UART receive path that fills the DRAM, and it owns the DRAM address mux input during TX mode. It also signals completion to the top-level mode controller.

## Interface
- ADDR_W, 16, DRAM address width
- DATA_W, 8, byte width (fixed 8 for UART)
- BASE_ADDR, 0, first DRAM address read
- NUM_BYTES, 65536, bytes per transfer; 1 ≤ NUM_BYTES and BASE_ADDR+NUM_BYTES ≤ 2^ADDR_W
- RD_LAT, 1, DRAM read latency (address presented → ram_q valid), legal 1..3
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- ram_addr  out  ADDR_W  DRAM read address
- ram_q  in  DATA_W  DRAM read data
- tx_dv  out  1  one-cycle strobe to transmitter (i_Tx_DV)
- tx_byte  out  DATA_W  byte to transmitter, held stable from tx_dv until tx_done
- tx_done  in  1  transmitter byte-complete pulse (o_Tx_Done)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last byte's tx_done

## Operation
- States: IDLE, FETCH, WAIT_RD, SEND, WAIT_TX, FINISH.
- IDLE: if start=1, load addr←BASE_ADDR and remaining←NUM_BYTES, then go to FETCH. Otherwise stay.
- FETCH: drive ram_addr=addr, load the latency counter with RD_LAT, and go to WAIT_RD.
- WAIT_RD: decrement the latency counter. When it reaches 0, register ram_q into tx_byte and go to SEND.
- SEND: tx_dv=1 for exactly this cycle, then go to WAIT_TX.
- WAIT_TX: on tx_done, remaining←remaining−1 and addr←addr+1.
  - If remaining was 1, go to FINISH.
  - Otherwise go to FETCH.
- FINISH: done=1 for one cycle, then return to IDLE.
- remaining is ADDR_W+1 bits wide, so NUM_BYTES=2^ADDR_W is representable.
- addr is ADDR_W bits and wraps mod 2^ADDR_W. The parameter legality rule guarantees no wrap within a transfer.
- ram_addr holds its last value outside FETCH/WAIT_RD. It is BASE_ADDR after reset.
- start while busy is ignored. It does not restart or queue a transfer.
- tx_done in any state other than WAIT_TX is ignored.
- tx_done in the same cycle as tx_dv (SEND) is ignored.
- start and done never overlap: FINISH always spends one cycle before IDLE samples start.
- Reset mid-transfer: immediate return to IDLE, all outputs go to reset values, and no done pulse is issued.

## Timing
- Reset values:
  - ram_addr=BASE_ADDR
  - tx_dv=0
  - tx_byte=0
  - busy=0
  - done=0
- Start accepted at cycle 0 (IDLE, start=1):
  - FETCH at cycle 1, with ram_addr=BASE_ADDR.
  - ram_q is sampled at cycle 1+RD_LAT.
  - tx_dv is high at cycle 2+RD_LAT.
- Per-byte overhead from tx_done to the next tx_dv is RD_LAT+2 cycles.
- From the last tx_done (cycle t), done is high at t+1 and busy is low at t+2.
- busy is high in FETCH, WAIT_RD, SEND, WAIT_TX and FINISH.
- tx_byte changes only on the WAIT_RD→SEND transition.

## Structure
- Shared include uart_img_defs.vh holds:
  - state encodings (3-bit, localparam)
  - IMG_ADDR_W=16
  - IMG_BYTES=65536
- This block and the write-side block both use these constants.
- Natural sub-module: rd_lat_delay, a small down-counter producing a "data valid" strike RD_LAT cycles after FETCH. It is reusable by other DRAM readers (e.g. the downsampler).
- The remaining logic is a single FSM in one always block with async reset.

## Test plan
- RD_LAT=1, NUM_BYTES=4, BASE_ADDR=0x0010, RAM preloaded with 0xA0..0xA3, transmitter model returns tx_done 10 cycles after each tx_dv.
  - Required: tx_byte sequence A0,A1,A2,A3 and exactly 4 tx_dv pulses.
  - Required: done 1 cycle after the 4th tx_done, busy low the following cycle.
- Latency check with RD_LAT=3, start at cycle 0.
  - Required: ram_addr=BASE at cycle 1 and tx_dv at cycle 5.
  - Required: tx_done→next tx_dv gap of 5 cycles.
- start pulsed again at the 2nd byte, plus a spurious tx_done during WAIT_RD.
  - Required: the transfer is unaffected, 4 bytes are sent, and a single done pulse is produced.
- NUM_BYTES=65536, BASE_ADDR=0, RAM holds addr[7:0].
  - Required: 65536 bytes equal to the address LSBs.
  - Required: last ram_addr=0xFFFF and done asserted with no early termination.
- Async rst asserted while in WAIT_TX of byte 2.
  - Required: tx_dv/busy/done low in the same cycle and ram_addr=BASE.
  - Required: a new start afterwards re-sends from BASE_ADDR.
